// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy draw stage: sprite geometry defaults,
// transparent colour key, life-state codes, pipeline depth and sprite art.
package enemy_pkg;

   localparam int          SPR_W_DEF   = 32;
   localparam int          SPR_H_DEF   = 32;
   localparam int          DRAW_LAT    = 3;
   localparam logic [11:0] TRANSPARENT = 12'hF0F;

   typedef enum logic [1:0] {
      ST_ALIVE = 2'd0,
      ST_EXPL  = 2'd1,
      ST_DEAD  = 2'd2
   } state_t;

   // VGA timing + background pixel as carried down the pipe
   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_t;

   // Sprite art as a fixed function of address {dy,dx} (row-major, 32 wide).
   // An 8x8 patch in the top-right corner is keyed out as transparent.
   function automatic logic [11:0] sprite_texel(input logic [15:0] a);
      logic [11:0] t;
      t = {a[9:6], a[5:2], a[1:0], 2'b01};
      if (a[4:3] == 2'b11 && a[9:8] == 2'b00) t = TRANSPARENT;
      return t;
   endfunction

endpackage

// File: rtl/draw_enemy_if.sv
// VGA pixel-stream bundle: timing, coordinates and pixel colour.
// master drives the stream, slave consumes it.
interface draw_enemy_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/enemy_sprite_rom.sv
// Enemy sprite ROM, SPR_W*SPR_H x 12 bit, registered output (1-cycle read).
module enemy_sprite_rom
   import enemy_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic          pclk,
   input  logic [AW-1:0] addr,
   output logic [11:0]   data
);

   // synchronous read; contents are constant, so no reset is needed
   always_ff @(posedge pclk)
      data <= sprite_texel(16'(addr));

endmodule

// File: rtl/draw_enemy.sv
// Enemy sprite overlay on the VGA stream with ALIVE/EXPLODING/DEAD life state.
// Three-stage pipe: S1 box test + address, S2 ROM read, S3 composite.
// Optional build macro ENEMY_FLASH_EN: while exploding the sprite flashes
// white on even frame counts instead of being hidden.
module draw_enemy
   import enemy_pkg::*;
#(
   parameter int SPR_W       = SPR_W_DEF,
   parameter int SPR_H       = SPR_H_DEF,
   parameter int EXPL_FRAMES = 16
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic [11:0]   xpos_in,
   input  logic [11:0]   ypos_in,
   input  logic          on_in,
   input  logic          hit_in,
   input  logic          respawn_in,
   draw_enemy_if.slave   vga_in,
   draw_enemy_if.master  vga_out,
   output logic          alive_out
);

   localparam int AX = $clog2(SPR_W);
   localparam int AY = $clog2(SPR_H);

   state_t       state, state_nxt;
   logic [7:0]   cnt, cnt_nxt;
   logic         vblnk_prev, vblnk_rise;
   logic [11:0]  xl, yl;
   logic         on_l;

   logic [12:0]  dx, dy;
   logic         in_box, draw_en, flash;

   vga_t              tim_in, tim_s1, tim_s2;
   logic [AY+AX-1:0]  addr_s1;
   logic              show_s1, show_s2, flash_s1, flash_s2;
   logic [11:0]       texel;

   assign vblnk_rise = vga_in.vblnk & ~vblnk_prev;
   assign alive_out  = (state == ST_ALIVE) && on_l;

   // capture position once per frame so the sprite never tears mid-frame
   always_ff @(posedge pclk) begin
      if (rst) begin
         vblnk_prev <= 1'b0;
         xl         <= '0;
         yl         <= '0;
         on_l       <= 1'b0;
      end else begin
         vblnk_prev <= vga_in.vblnk;
         if (vblnk_rise) begin
            xl   <= xpos_in;
            yl   <= ypos_in;
            on_l <= on_in;
         end
      end
   end

   // life-state register
   always_ff @(posedge pclk) begin
      if (rst) begin
         state <= ST_ALIVE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // life-state transitions; each pulse only acts in the state where it is legal
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_ALIVE: if (hit_in && on_l) begin
            state_nxt = ST_EXPL;
            cnt_nxt   = '0;
         end
         ST_EXPL: if (vblnk_rise) begin
            if (cnt == 8'(EXPL_FRAMES-1)) state_nxt = ST_DEAD;
            else                          cnt_nxt   = cnt + 8'd1;
         end
         ST_DEAD: if (respawn_in) state_nxt = ST_ALIVE;
         default: state_nxt = ST_ALIVE;
      endcase
   end

   // S1 box test: 13-bit subtraction so a position left/above the pixel
   // shows up as a borrow and counts as outside
   always_comb begin
      dx     = {2'b00, vga_in.hcount} - {1'b0, xl};
      dy     = {2'b00, vga_in.vcount} - {1'b0, yl};
      in_box = !dx[12] && !dy[12] &&
               (dx[11:0] < 12'(SPR_W)) && (dy[11:0] < 12'(SPR_H));
`ifdef ENEMY_FLASH_EN
      draw_en = on_l && (state == ST_ALIVE || state == ST_EXPL);
      flash   = (state == ST_EXPL) && !cnt[0];
`else
      draw_en = on_l && (state == ST_ALIVE);
      flash   = 1'b0;
`endif
      tim_in  = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                  hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                  hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk,
                  rgb:    vga_in.rgb};
   end

   // S1 register: timing, ROM address and draw decision
   always_ff @(posedge pclk) begin
      if (rst) begin
         tim_s1   <= '0;
         addr_s1  <= '0;
         show_s1  <= 1'b0;
         flash_s1 <= 1'b0;
      end else begin
         tim_s1   <= tim_in;
         addr_s1  <= {dy[AY-1:0], dx[AX-1:0]};
         show_s1  <= in_box && draw_en;
         flash_s1 <= flash;
      end
   end

   enemy_sprite_rom #(.AW(AY+AX)) u_rom (
      .pclk (pclk),
      .addr (addr_s1),
      .data (texel)
   );

   // S2 register: keep side-band aligned with the ROM read
   always_ff @(posedge pclk) begin
      if (rst) begin
         tim_s2   <= '0;
         show_s2  <= 1'b0;
         flash_s2 <= 1'b0;
      end else begin
         tim_s2   <= tim_s1;
         show_s2  <= show_s1;
         flash_s2 <= flash_s1;
      end
   end

   // S3 composite: blanking wins, then opaque sprite texel, else background
   always_ff @(posedge pclk) begin
      if (rst) begin
         vga_out.hcount <= '0;
         vga_out.vcount <= '0;
         vga_out.hsync  <= 1'b0;
         vga_out.vsync  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
         vga_out.rgb    <= '0;
      end else begin
         vga_out.hcount <= tim_s2.hcount;
         vga_out.vcount <= tim_s2.vcount;
         vga_out.hsync  <= tim_s2.hsync;
         vga_out.vsync  <= tim_s2.vsync;
         vga_out.hblnk  <= tim_s2.hblnk;
         vga_out.vblnk  <= tim_s2.vblnk;
         if (tim_s2.hblnk || tim_s2.vblnk)
            vga_out.rgb <= 12'h000;
         else if (show_s2 && texel != TRANSPARENT)
            vga_out.rgb <= flash_s2 ? 12'hFFF : texel;
         else
            vga_out.rgb <= tim_s2.rgb;
      end
   end

endmodule
